vpu_req_arbiter: RTL
====================

// Module: vpu_req_arbiter
// PURPOSE
//  Shares one VPU_TOP request port among NUM_REQ host requesters using round-robin arbitration.
//  Holds the granted instruction in a registered output stage and limits in-flight instructions
//  to MAX_OUTSTANDING with a credit counter. Records requester IDs in an in-order tag FIFO so each
//  dst0 write-completion is returned to the requester that issued the instruction.
//  Sits between the host request fabric and VPU_TOP's vpu_req_if.
// PARAMETERS
//  NUM_REQ          3   number of requesters, 2..8
//  INSTR_W          40  instruction width {opcode[7:0], src2, src1, src0, dst0}
//  MAX_OUTSTANDING  4   max instructions accepted but not yet completed, power of 2, 2..16
// PORTS
//  clk            in   1                   clock
//  rst_n          in   1                   reset (see below)
//  req_valid_i    in   NUM_REQ             per-requester instruction valid
//  req_instr_i    in   NUM_REQ*INSTR_W     per-requester instruction; slice i = requester i
//  req_ready_o    out  NUM_REQ             one-hot accept; handshake = valid & ready
//  vpu_valid_o    out  1                   instruction valid to VPU
//  vpu_instr_o    out  INSTR_W             instruction to VPU
//  vpu_ready_i    in   1                   VPU accepts instruction
//  wr_done_i      in   1                   1-cycle pulse per completed dst0 SRAM write (in order)
//  done_o         out  NUM_REQ             1-cycle completion pulse to the originating requester
//  drain_i        in   1                   level: stop granting and wait for empty
//  drain_ack_o    out  1                   high while drained (state IDLE)
//  outstanding_o  out  $clog2(MAX_OUTSTANDING)+1   current credit count
//  err_o          out  1                   sticky: wr_done_i received with tag FIFO empty
// BEHAVIOUR
//  - Reset rst_n, asynchronous, active-high; clock clk. While rst_n=1, all outputs are 0,
//    rr_ptr=0, credits=0, tag FIFO empty, and FSM=RUN. Reset mid-operation discards held and
//    in-flight state; completions arriving after reset release set err_o.
//  - can_load = !vpu_valid_o | vpu_ready_i.
//    grant_ok = FSM==RUN & can_load & (outstanding_o < MAX_OUTSTANDING).
//  - Grant (combinational): when grant_ok, scan req_valid_i starting at index rr_ptr, ascending
//    with wrap. The first valid requester g gets req_ready_o[g]=1. At most one bit of
//    req_ready_o is high. req_ready_o never depends on vpu_ready_i except through can_load.
//  - On accept of requester g:
//    - vpu_instr_o <= slice g and vpu_valid_o <= 1 (next cycle; 1-cycle request-to-VPU latency).
//    - rr_ptr <= (g+1) mod NUM_REQ.
//    - tag FIFO push g; credits +1.
//  - On vpu_valid_o & vpu_ready_i with no new accept: vpu_valid_o <= 0. Accept in the same cycle
//    gives back-to-back issue at 1 instr/cycle.
//  - vpu_instr_o is held stable while vpu_valid_o=1 and vpu_ready_i=0.
//  - wr_done_i with FIFO non-empty: pop head h; done_o[h] pulses the next cycle; credits -1.
//  - Simultaneous accept and wr_done: credits unchanged; push and pop both occur.
//  - FIFO full coincides with credits == MAX_OUTSTANDING, so no grant is possible.
//  - wr_done_i with FIFO empty: ignored (no pop, no done_o, credits stay 0); err_o <= 1 until reset.
//  - FSM:
//    - RUN -> DRAIN when drain_i=1 (grants blocked that cycle onward).
//    - DRAIN -> IDLE when credits==0 & !vpu_valid_o.
//    - IDLE -> RUN when drain_i=0.
//    - drain_ack_o = (FSM==IDLE). A held output instruction still issues during DRAIN.
//  - Credit counter width $clog2(MAX_OUTSTANDING)+1; never wraps.
// CONFIGURATION
//  - VPU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr removed, scan always
//    starts at 0. All other behaviour is unchanged.
//  - Undefined (default): round-robin as above.
// TESTING
//  1. All 3 requesters valid, vpu_ready_i=1, wr_done_i every cycle -> grant order 0,1,2,0,1,2.
//     vpu_instr_o equals the accepted slice one cycle later; outstanding_o never exceeds 2.
//  2. vpu_ready_i=0, req 1 valid, no wr_done -> 1 accept; vpu_instr_o held; further req_ready_o=0.
//     Then raise vpu_ready_i with wr_done_i=0 for 3 more accepts -> outstanding_o=4, all
//     req_ready_o=0 until wr_done_i.
//  3. Accept from reqs 2,0,1, then 3 wr_done_i pulses -> done_o pulses 3'b100, 3'b001, 3'b010
//     each 1 cycle after the pulse; outstanding_o returns to 0.
//  4. Pulse wr_done_i with outstanding_o=0 -> err_o=1 and stays 1; done_o stays 0; counter stays 0.
//  5. drain_i=1 with 2 outstanding -> no grants; drain_ack_o rises 1 cycle after the 2nd wr_done
//     is absorbed. drain_i=0 -> grants resume the next cycle.
//  6. Assert rst_n mid-burst with 3 outstanding -> all outputs 0 immediately (async); after
//     release, the first grant goes to requester 0. With VPU_ARB_FIXED_PRIO_EN and reqs 0,2
//     valid -> req 0 granted every cycle.

Source files
------------

// File: rtl/vpu_req_arbiter.sv
// vpu_req_arbiter: shares one VPU request port among NUM_REQ host requesters.
//   - round-robin grant; registered output stage toward the VPU
//   - credit counter caps the number of in-flight instructions at MAX_OUTSTANDING
//   - in-order tag FIFO routes each dst0 write completion back to its requester
//   - drain handshake (RUN/DRAIN/IDLE) for quiescing the port
// Build option: define VPU_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer). Default build is round-robin.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal operation, grants allowed
// ST_DRAIN | grants blocked, waiting for credits==0 and output empty
// ST_IDLE  | drained, drain_ack_o high, resume when drain_i drops
//
// Requester identity is carried one-hot throughout (pointer, FIFO tags,
// grant), so the done pulse is the FIFO head itself and no encoder or
// decoder is needed.

module vpu_req_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int INSTR_W         = 40,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*INSTR_W-1:0]         req_instr_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic                               vpu_valid_o,
  output logic [INSTR_W-1:0]                 vpu_instr_o,
  input  logic                               vpu_ready_i,
  input  logic                               wr_done_i,
  output logic [NUM_REQ-1:0]                 done_o,
  input  logic                               drain_i,
  output logic                               drain_ack_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int AW    = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_drain_ack;
  logic [CNT_W-1:0]      r_credits;
  logic                  r_err;
  logic                  r_vpu_valid;
  logic [INSTR_W-1:0]    r_vpu_instr;
  logic [NUM_REQ-1:0]    r_done;
  logic [NUM_REQ-1:0]    r_fifo [MAX_OUTSTANDING];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;

  logic                  w_can_load;
  logic                  w_grant_ok;
  logic [NUM_REQ-1:0]    w_pick;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_accept;
  logic                  w_pop;
  logic [INSTR_W-1:0]    w_sel_instr;
  logic [INSTR_W-1:0]    w_or_chain [NUM_REQ+1];

  assign w_can_load = !r_vpu_valid || vpu_ready_i;
  // Reset term keeps req_ready_o low while reset is held, even if requests are valid.
  assign w_grant_ok = !rst_n && (r_state == ST_RUN) && w_can_load && (r_credits < CNT_MAX);

`ifdef VPU_ARB_FIXED_PRIO_EN
  assign w_pick = req_valid_i;
`else
  logic [NUM_REQ-1:0] r_rr_oh;
  logic [NUM_REQ-1:0] w_below_ptr;
  logic [NUM_REQ-1:0] w_req_hi;

  // r_rr_oh is one-hot (never zero), so subtracting one marks every index below the pointer.
  assign w_below_ptr = r_rr_oh - NUM_REQ'(1);
  assign w_req_hi    = req_valid_i & ~w_below_ptr;
  assign w_pick      = (|w_req_hi) ? w_req_hi : req_valid_i;

  // Pointer moves to the index just above the winner, wrapping to 0.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rr_oh <= NUM_REQ'(1);
    end else if (w_accept) begin
      r_rr_oh <= {w_grant[NUM_REQ-2:0], w_grant[NUM_REQ-1]};
    end
  end
`endif

  // Lowest set bit of the candidate vector is the winner.
  assign w_grant     = w_grant_ok ? (w_pick & (~w_pick + NUM_REQ'(1))) : '0;
  assign w_accept    = |w_grant;
  assign req_ready_o = w_grant;

  // AND-OR mux of the granted slice; grant is one-hot so at most one term is non-zero.
  assign w_or_chain[0] = '0;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
    assign w_or_chain[gi+1] = w_or_chain[gi] |
                              (req_instr_i[gi*INSTR_W +: INSTR_W] & {INSTR_W{w_grant[gi]}});
  end
  assign w_sel_instr = w_or_chain[NUM_REQ];

  // Credits equal FIFO occupancy, so a pop is only legal while credits are non-zero.
  assign w_pop = wr_done_i && (r_credits != '0);

  // Output stage: load on accept, clear once the VPU takes it, otherwise hold.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_vpu_valid <= 1'b0;
      r_vpu_instr <= '0;
    end else if (w_accept) begin
      r_vpu_valid <= 1'b1;
      r_vpu_instr <= w_sel_instr;
    end else if (r_vpu_valid && vpu_ready_i) begin
      r_vpu_valid <= 1'b0;
    end
  end

  // Tag FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fifo[r_wr_ptr] <= w_grant;
    end
  end

  // FIFO pointers, credit counter, completion pulse and sticky error.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_credits <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_done <= w_pop ? r_fifo[r_rd_ptr] : '0;
      case ({w_accept, w_pop})
        2'b10:   r_credits <= r_credits + CNT_W'(1);
        2'b01:   r_credits <= r_credits - CNT_W'(1);
        default: r_credits <= r_credits;
      endcase
      if (wr_done_i && (r_credits == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Drain FSM with registered acknowledge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= ST_RUN;
      r_drain_ack <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (drain_i) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((r_credits == '0) && !r_vpu_valid) begin
            r_state     <= ST_IDLE;
            r_drain_ack <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (!drain_i) begin
            r_state     <= ST_RUN;
            r_drain_ack <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_drain_ack <= 1'b0;
        end
      endcase
    end
  end

  assign vpu_valid_o   = r_vpu_valid;
  assign vpu_instr_o   = r_vpu_instr;
  assign done_o        = r_done;
  assign drain_ack_o   = r_drain_ack;
  assign outstanding_o = r_credits;
  assign err_o         = r_err;

endmodule
